cfu_mac_sequencer: RTL and testbench

//  CFU front end that owns the SIMD MAC datapath (4x int8 products + accumulate) and sequences it.
//  CPU preloads two DEPTH-word operand buffers (A: packed input bytes, B: packed filter bytes),

---
 rtl/cfu_mac_sequencer.sv | 173 +++++++++++++++++
 tb/tb_cfu_mac_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cfu_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cfu_mac_sequencer
//  Description : CFU front end. Holds two operand buffers and sequences a
//                clear/stream/drain pass of the external SIMD MAC per RUN.
//  Revision    : 1.0  initial release
// ============================================================================
module cfu_mac_sequencer #(
    parameter int DEPTH       = 8,
    parameter int ADDR_W      = 3,
    parameter int MAC_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    input  logic [31:0] cmd_payload_inputs_1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_payload_outputs_0,
    output logic        mac_clear,
    output logic        mac_valid,
    output logic [31:0] mac_in0,
    output logic [31:0] mac_in1,
    input  logic [31:0] mac_acc,
    output logic        busy
);

    localparam int DRAIN_W = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;

    localparam logic [2:0] C_OP_WRITE_A  = 3'd0;
    localparam logic [2:0] C_OP_WRITE_B  = 3'd1;
    localparam logic [2:0] C_OP_RUN      = 3'd2;
    localparam logic [2:0] C_OP_READ_ACC = 3'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t              r_state;
    logic [31:0]         r_buf_a [DEPTH];
    logic [31:0]         r_buf_b [DEPTH];
    logic [ADDR_W-1:0]   r_idx;
    logic [ADDR_W:0]     r_cnt;
    logic [DRAIN_W-1:0]  r_drain;
    logic                r_cmd_ready;
    logic                r_busy;
    logic                r_rsp_valid;
    logic [31:0]         r_rsp_data;
    logic                r_mac_clear;
    logic                r_mac_valid;
    logic [31:0]         r_mac_in0;
    logic [31:0]         r_mac_in1;

    logic                w_accept;
    logic [2:0]          w_op;
    logic [ADDR_W-1:0]   w_wr_idx;
    logic [ADDR_W:0]     w_run_cnt;
    logic                w_unused;

    assign w_accept  = cmd_valid && r_cmd_ready;
    assign w_op      = cmd_payload_function_id[2:0];
    assign w_wr_idx  = cmd_payload_inputs_0[ADDR_W-1:0];
    // Counts beyond the buffer depth are clamped so each word streams once.
    assign w_run_cnt = (cmd_payload_inputs_0 > 32'(DEPTH)) ? (ADDR_W+1)'(DEPTH)
                                                           : cmd_payload_inputs_0[ADDR_W:0];
    assign w_unused  = &{1'b0, cmd_payload_function_id[9:3]};

    // Buffers carry no reset so their contents survive a reset.
    always_ff @(posedge clk) begin
        if (!reset && w_accept) begin
            if (w_op == C_OP_WRITE_A) r_buf_a[w_wr_idx] <= cmd_payload_inputs_1;
            if (w_op == C_OP_WRITE_B) r_buf_b[w_wr_idx] <= cmd_payload_inputs_1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_drain     <= '0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_mac_clear <= 1'b0;
            r_mac_valid <= 1'b0;
            r_mac_in0   <= '0;
            r_mac_in1   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cmd_ready <= 1'b0;
                        if (w_op == C_OP_RUN) begin
                            r_state     <= S_CLEAR;
                            r_busy      <= 1'b1;
                            r_mac_clear <= 1'b1;
                            r_cnt       <= w_run_cnt;
                            r_idx       <= cmd_payload_inputs_1[ADDR_W-1:0];
                        end else begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= (w_op == C_OP_READ_ACC) ? mac_acc : 32'd0;
                        end
                    end
                end
                // CLEAR and STREAM share the "issue next word or go drain" step.
                S_CLEAR, S_STREAM: begin
                    r_mac_clear <= 1'b0;
                    if (r_cnt != '0) begin
                        r_state     <= S_STREAM;
                        r_mac_valid <= 1'b1;
                        r_mac_in0   <= r_buf_a[r_idx];
                        r_mac_in1   <= r_buf_b[r_idx];
                        r_idx       <= r_idx + 1'b1;
                        r_cnt       <= r_cnt - 1'b1;
                    end else begin
                        r_state     <= S_DRAIN;
                        r_mac_valid <= 1'b0;
                        r_mac_in0   <= '0;
                        r_mac_in1   <= '0;
                        r_drain     <= DRAIN_W'(MAC_LATENCY - 1);
                    end
                end
                S_DRAIN: begin
                    if (r_drain == '0) begin
                        r_state     <= S_RESP;
                        r_busy      <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= mac_acc;
                    end else begin
                        r_drain <= r_drain - 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rsp_data  <= '0;
                        r_cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cmd_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_mac_clear <= 1'b0;
                    r_mac_valid <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready             = r_cmd_ready;
    assign busy                  = r_busy;
    assign rsp_valid             = r_rsp_valid;
    assign rsp_payload_outputs_0 = r_rsp_data;
    assign mac_clear             = r_mac_clear;
    assign mac_valid             = r_mac_valid;
    assign mac_in0               = r_mac_in0;
    assign mac_in1               = r_mac_in1;

endmodule
`default_nettype wire

// File: tb/tb_cfu_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cfu_mac_sequencer
//  Description : Scoreboard bench for cfu_mac_sequencer with a reference MAC.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cfu_mac_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  cmd_payload_function_id = '0;
    logic [31:0] cmd_payload_inputs_0 = '0;
    logic [31:0] cmd_payload_inputs_1 = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_payload_outputs_0;
    logic        mac_clear;
    logic        mac_valid;
    logic [31:0] mac_in0;
    logic [31:0] mac_in1;
    logic [31:0] mac_acc = '0;
    logic        busy;

    cfu_mac_sequencer #(.DEPTH(8), .ADDR_W(3), .MAC_LATENCY(1)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_payload_function_id(cmd_payload_function_id),
        .cmd_payload_inputs_0(cmd_payload_inputs_0),
        .cmd_payload_inputs_1(cmd_payload_inputs_1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_payload_outputs_0(rsp_payload_outputs_0),
        .mac_clear(mac_clear), .mac_valid(mac_valid),
        .mac_in0(mac_in0), .mac_in1(mac_in1),
        .mac_acc(mac_acc), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          n_valid = 0;
    int          n_clear = 0;
    bit          in_rsp = 1'b0;
    logic [31:0] held = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference MAC: acc += sum (signed(a)+128)*signed(b), one-cycle latency.
    function automatic logic [31:0] dot4(input logic [31:0] a, input logic [31:0] b);
        int s = 0;
        logic signed [7:0] ab, bb;
        for (int i = 0; i < 4; i++) begin
            ab = a[8*i +: 8];
            bb = b[8*i +: 8];
            s += (int'(ab) + 128) * int'(bb);
        end
        return 32'(s);
    endfunction

    always @(posedge clk) begin
        if (mac_clear)      mac_acc <= '0;
        else if (mac_valid) mac_acc <= mac_acc + dot4(mac_in0, mac_in1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a new response appears.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            in_rsp = 1'b0;
        end else begin
            chk("clear_and_valid_exclusive", 32'(mac_clear && mac_valid), 32'd0);
            if (!mac_valid) chk("mac_in_zero_when_idle", mac_in0 | mac_in1, 32'd0);
            n_valid += int'(mac_valid);
            n_clear += int'(mac_clear);
            if (rsp_valid) begin
                chk("cmd_ready_low_in_resp", 32'(cmd_ready), 32'd0);
                if (!in_rsp) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_response", rsp_payload_outputs_0, 32'hFFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_data", rsp_payload_outputs_0, e.data);
                        chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
                    end
                    held   = rsp_payload_outputs_0;
                    in_rsp = 1'b1;
                end else begin
                    chk("rsp_payload_stable", rsp_payload_outputs_0, held);
                end
                if (rsp_ready) in_rsp = 1'b0;
            end else if (in_rsp) begin
                chk("rsp_valid_dropped", 32'(rsp_valid), 32'd1);
                in_rsp = 1'b0;
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] exp, input int lat, input bit push);
        int guard = 0;
        @(posedge clk); #1;
        cmd_valid               = 1'b1;
        cmd_payload_function_id = {7'h55, op};
        cmd_payload_inputs_0    = a0;
        cmd_payload_inputs_1    = a1;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            guard++;
            if (guard > 50) begin
                chk("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
                break;
            end
        end
        if (push) sb.push_back('{data: exp, cyc: cyc + lat});
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        forever begin
            @(negedge clk);
            if (cmd_ready) break;
            guard++;
            if (guard > 100) begin
                chk("idle_timeout", 32'(cmd_ready), 32'd1);
                break;
            end
        end
    endtask

    task automatic cmd(input logic [2:0] op, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] exp, input int lat);
        issue(op, a0, a1, exp, lat, 1'b1);
        wait_idle();
    endtask

    initial begin
        int v0, c0, guard;

        // Reset held three cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_payload", rsp_payload_outputs_0, 32'd0);
        chk("reset_mac_ctrl", {30'd0, mac_clear, mac_valid}, 32'd0);
        chk("reset_mac_in", mac_in0 | mac_in1, 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single-word run
        cmd(3'd0, 32'd3, 32'h01020304, 32'd0, 1);
        cmd(3'd1, 32'd3, 32'h01010101, 32'd0, 1);
        cmd(3'd2, 32'd1, 32'd3, 32'd522, 4);

        // Wrapping run over uniform buffers
        for (int i = 0; i < 8; i++) begin
            cmd(3'd0, 32'(i), 32'h01010101, 32'd0, 1);
            cmd(3'd1, 32'(i), 32'h01010101, 32'd0, 1);
        end
        v0 = n_valid;
        cmd(3'd2, 32'd3, 32'd6, 32'd1548, 6);
        chk("run3_valid_cycles", 32'(n_valid - v0), 32'd3);

        // Distinct A words prove the index order 6,7,0
        for (int i = 0; i < 8; i++) cmd(3'd0, 32'(i), 32'(i + 1), 32'd0, 1);
        cmd(3'd2, 32'd3, 32'd6, 32'd1552, 6);

        // Zero and over-length counts
        v0 = n_valid; c0 = n_clear;
        cmd(3'd2, 32'd0, 32'd0, 32'd0, 3);
        chk("run0_valid_cycles", 32'(n_valid - v0), 32'd0);
        chk("run0_clear_cycles", 32'(n_clear - c0), 32'd1);
        v0 = n_valid;
        cmd(3'd2, 32'd20, 32'd0, 32'd4132, 11);
        chk("run20_valid_cycles", 32'(n_valid - v0), 32'd8);
        cmd(3'd3, 32'd0, 32'd0, 32'd4132, 1);
        cmd(3'd7, 32'd5, 32'd5, 32'd0, 1);

        // Back-pressure with a concurrent command that must be ignored
        rsp_ready = 1'b0;
        issue(3'd2, 32'd1, 32'd3, 32'd516, 4, 1'b1);
        guard = 0;
        while (!rsp_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("bp_rsp_seen", 32'(rsp_valid), 32'd1);
        @(posedge clk); #1;
        cmd_valid               = 1'b1;
        cmd_payload_function_id = 10'd0;
        cmd_payload_inputs_0    = 32'd0;
        cmd_payload_inputs_1    = 32'h7F7F7F7F;
        repeat (5) @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle();
        cmd(3'd2, 32'd1, 32'd0, 32'd513, 4);

        // Reset in the middle of a stream
        issue(3'd2, 32'd8, 32'd0, 32'd0, 0, 1'b0);
        repeat (3) @(negedge clk);
        chk("mid_stream_valid", 32'(mac_valid), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_mac_valid", 32'(mac_valid), 32'd0);
        chk("post_reset_busy", 32'(busy), 32'd0);
        chk("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        cmd(3'd1, 32'd2, 32'h02020202, 32'd0, 1);
        cmd(3'd2, 32'd1, 32'd2, 32'd1030, 4);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
